demux_1t2_stream: RTL and testbench

//   Registered 1-to-2 stream demultiplexer: the routing counterpart of the 2:1 data mux (MUX2T1).

---
 rtl/demux_1t2_stream.sv | 119 +++++++++++
 tb/tb_demux_1t2_stream.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/demux_1t2_stream.sv
// Registered 1-to-2 valid/ready stream demultiplexer.
// Each input word is routed by SEL into a one-entry holding register on
// channel 0 or 1. Each channel is an EMPTY/FULL FSM that can drain and
// reload in the same cycle, so each channel sustains one word per cycle.
// Ports:
//   CLK, RST_N            clock, asynchronous active-low reset
//   DIN, SEL, IN_VALID    input word, destination channel, word present
//   IN_READY              input accepted this cycle (combinational)
//   DOUTn, OUTn_VALID     channel n registered data / undelivered flag
//   OUTn_READY            channel n consumer takes DOUTn this cycle
//   CNTn                  words accepted into channel n since reset (wraps)
module demux_1t2_stream #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [WIDTH-1:0] DIN,
  input  logic             SEL,
  input  logic             IN_VALID,
  output logic             IN_READY,
  output logic [WIDTH-1:0] DOUT0,
  output logic             OUT0_VALID,
  input  logic             OUT0_READY,
  output logic [WIDTH-1:0] DOUT1,
  output logic             OUT1_VALID,
  input  logic             OUT1_READY,
  output logic [CNT_W-1:0] CNT0,
  output logic [CNT_W-1:0] CNT1
);

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } ch_state_e;

  ch_state_e        st0_q, st0_d;
  ch_state_e        st1_q, st1_d;
  logic [WIDTH-1:0] data0_q, data0_d;
  logic [WIDTH-1:0] data1_q, data1_d;
  logic [CNT_W-1:0] cnt0_q, cnt0_d;
  logic [CNT_W-1:0] cnt1_q, cnt1_d;

  logic space0, space1;
  logic drain0, drain1;
  logic accept, load0, load1;

  // Handshake decode; IN_READY depends only on SEL and the selected channel.
  always_comb begin
    space0   = (st0_q == ST_EMPTY) | OUT0_READY;
    space1   = (st1_q == ST_EMPTY) | OUT1_READY;
    drain0   = (st0_q == ST_FULL) & OUT0_READY;
    drain1   = (st1_q == ST_FULL) & OUT1_READY;
    IN_READY = SEL ? space1 : space0;
    accept   = IN_VALID & IN_READY;
    load0    = accept & ~SEL;
    load1    = accept & SEL;
  end

  // Channel 0 next state: load wins over drain so a drain+load has no bubble.
  always_comb begin
    st0_d   = st0_q;
    data0_d = data0_q;
    cnt0_d  = cnt0_q;
    case (st0_q)
      ST_EMPTY: if (load0) st0_d = ST_FULL;
      ST_FULL:  if (!load0 && drain0) st0_d = ST_EMPTY;
      default:  st0_d = ST_EMPTY;
    endcase
    if (load0) begin
      data0_d = DIN;
      cnt0_d  = cnt0_q + CNT_W'(1);
    end
  end

  // Channel 1 next state, mirror of channel 0.
  always_comb begin
    st1_d   = st1_q;
    data1_d = data1_q;
    cnt1_d  = cnt1_q;
    case (st1_q)
      ST_EMPTY: if (load1) st1_d = ST_FULL;
      ST_FULL:  if (!load1 && drain1) st1_d = ST_EMPTY;
      default:  st1_d = ST_EMPTY;
    endcase
    if (load1) begin
      data1_d = DIN;
      cnt1_d  = cnt1_q + CNT_W'(1);
    end
  end

  // State, data and counter registers.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      st0_q   <= ST_EMPTY;
      st1_q   <= ST_EMPTY;
      data0_q <= '0;
      data1_q <= '0;
      cnt0_q  <= '0;
      cnt1_q  <= '0;
    end else begin
      st0_q   <= st0_d;
      st1_q   <= st1_d;
      data0_q <= data0_d;
      data1_q <= data1_d;
      cnt0_q  <= cnt0_d;
      cnt1_q  <= cnt1_d;
    end
  end

  // FULL is the valid flag; all of these come straight from flops.
  assign OUT0_VALID = (st0_q == ST_FULL);
  assign OUT1_VALID = (st1_q == ST_FULL);
  assign DOUT0      = data0_q;
  assign DOUT1      = data1_q;
  assign CNT0       = cnt0_q;
  assign CNT1       = cnt1_q;

endmodule

// File: tb/tb_demux_1t2_stream.sv
// Directed testbench for demux_1t2_stream.
module tb_demux_1t2_stream;

  logic        CLK;
  logic        RST_N;
  logic [31:0] DIN;
  logic        SEL;
  logic        IN_VALID;
  logic        IN_READY;
  logic [31:0] DOUT0;
  logic        OUT0_VALID;
  logic        OUT0_READY;
  logic [31:0] DOUT1;
  logic        OUT1_VALID;
  logic        OUT1_READY;
  logic [15:0] CNT0;
  logic [15:0] CNT1;

  int n_pass  = 0;
  int n_total = 0;

  demux_1t2_stream #(.WIDTH(32), .CNT_W(16)) dut (
    .CLK(CLK), .RST_N(RST_N), .DIN(DIN), .SEL(SEL), .IN_VALID(IN_VALID),
    .IN_READY(IN_READY), .DOUT0(DOUT0), .OUT0_VALID(OUT0_VALID),
    .OUT0_READY(OUT0_READY), .DOUT1(DOUT1), .OUT1_VALID(OUT1_VALID),
    .OUT1_READY(OUT1_READY), .CNT0(CNT0), .CNT1(CNT1)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1, "watchdog");
  end

  // Advance one rising edge and settle 1 time unit past it.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Reset with idle inputs; returns 1 unit after the first edge out of reset.
  task automatic do_reset();
    RST_N = 1'b0; IN_VALID = 1'b0; SEL = 1'b0; DIN = '0;
    OUT0_READY = 1'b0; OUT1_READY = 1'b0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RST_N = 1'b1;
    step();
  endtask

  task automatic test_reset();
    RST_N = 1'b0; IN_VALID = 1'b0; SEL = 1'b0; DIN = '0;
    OUT0_READY = 1'b0; OUT1_READY = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    n_total++;
    if ({OUT0_VALID, OUT1_VALID, DOUT0, DOUT1, CNT0, CNT1} !== '0)
      $display("FAIL reset_outputs: got v0=%b v1=%b d0=%h d1=%h c0=%0d c1=%0d, want all 0",
               OUT0_VALID, OUT1_VALID, DOUT0, DOUT1, CNT0, CNT1);
    else n_pass++;
    n_total++;
    if (IN_READY !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", IN_READY);
    else n_pass++;
    @(negedge CLK);
    RST_N = 1'b1;
    step();
    n_total++;
    if ({OUT0_VALID, OUT1_VALID, CNT0, CNT1} !== '0 || IN_READY !== 1'b1)
      $display("FAIL post_reset_idle: got v0=%b v1=%b c0=%0d c1=%0d rdy=%b, want 0 0 0 0 1",
               OUT0_VALID, OUT1_VALID, CNT0, CNT1, IN_READY);
    else n_pass++;
  endtask

  task automatic test_single();
    OUT0_READY = 1'b1; OUT1_READY = 1'b1;
    DIN = 32'hdeadbeef; SEL = 1'b0; IN_VALID = 1'b1;
    step();
    IN_VALID = 1'b0;
    n_total++;
    if (DOUT0 !== 32'hdeadbeef || OUT0_VALID !== 1'b1 || CNT0 !== 16'd1)
      $display("FAIL single_ch0: got d0=%h v0=%b c0=%0d, want deadbeef 1 1", DOUT0, OUT0_VALID, CNT0);
    else n_pass++;
    n_total++;
    if (OUT1_VALID !== 1'b0 || CNT1 !== 16'd0)
      $display("FAIL single_ch1_idle: got v1=%b c1=%0d, want 0 0", OUT1_VALID, CNT1);
    else n_pass++;
    // Drained with nothing new: valid drops, data is kept.
    step();
    n_total++;
    if (OUT0_VALID !== 1'b0 || DOUT0 !== 32'hdeadbeef)
      $display("FAIL single_drain: got v0=%b d0=%h, want 0 deadbeef", OUT0_VALID, DOUT0);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] words [4];
    logic        sels  [4];
    int          bad;
    words = '{32'hdeadbeef, 32'hfeedfeed, 32'hbeeeeeef, 32'hdaffadad};
    sels  = '{1'b0, 1'b1, 1'b0, 1'b1};
    bad = 0;
    do_reset();
    OUT0_READY = 1'b1; OUT1_READY = 1'b1;
    for (int i = 0; i < 4; i++) begin
      DIN = words[i]; SEL = sels[i]; IN_VALID = 1'b1;
      #1;
      n_total++;
      if (IN_READY !== 1'b1) $display("FAIL b2b_in_ready[%0d]: got %b want 1", i, IN_READY);
      else n_pass++;
      step();
      n_total++;
      if (sels[i] == 1'b0) begin
        if (DOUT0 !== words[i] || OUT0_VALID !== 1'b1 || OUT1_VALID !== 1'b0)
          $display("FAIL b2b_word[%0d]: got d0=%h v0=%b v1=%b, want %h 1 0",
                   i, DOUT0, OUT0_VALID, OUT1_VALID, words[i]);
        else n_pass++;
      end else begin
        if (DOUT1 !== words[i] || OUT1_VALID !== 1'b1 || OUT0_VALID !== 1'b0)
          $display("FAIL b2b_word[%0d]: got d1=%h v1=%b v0=%b, want %h 1 0",
                   i, DOUT1, OUT1_VALID, OUT0_VALID, words[i]);
        else n_pass++;
      end
    end
    IN_VALID = 1'b0;
    n_total++;
    if (CNT0 !== 16'd2 || CNT1 !== 16'd2)
      $display("FAIL b2b_counts: got c0=%0d c1=%0d, want 2 2", CNT0, CNT1);
    else n_pass++;
    if (bad != 0) $display("FAIL b2b_internal: got %0d want 0", bad);
  endtask

  task automatic test_hol_block();
    do_reset();
    OUT0_READY = 1'b1; OUT1_READY = 1'b0;
    DIN = 32'hfeedfeed; SEL = 1'b1; IN_VALID = 1'b1;
    step();
    DIN = 32'h11111111; SEL = 1'b1;
    #1;
    n_total++;
    if (IN_READY !== 1'b0) $display("FAIL hol_stall_ready: got %b want 0", IN_READY);
    else n_pass++;
    step();
    n_total++;
    if (DOUT1 !== 32'hfeedfeed || OUT1_VALID !== 1'b1 || CNT1 !== 16'd1 || OUT0_VALID !== 1'b0)
      $display("FAIL hol_hold: got d1=%h v1=%b c1=%0d v0=%b, want feedfeed 1 1 0",
               DOUT1, OUT1_VALID, CNT1, OUT0_VALID);
    else n_pass++;
    DIN = 32'h22222222; SEL = 1'b0;
    #1;
    n_total++;
    if (IN_READY !== 1'b1) $display("FAIL hol_other_ready: got %b want 1", IN_READY);
    else n_pass++;
    step();
    n_total++;
    if (DOUT0 !== 32'h22222222 || OUT0_VALID !== 1'b1 || CNT0 !== 16'd1 || DOUT1 !== 32'hfeedfeed)
      $display("FAIL hol_other_load: got d0=%h v0=%b c0=%0d d1=%h, want 22222222 1 1 feedfeed",
               DOUT0, OUT0_VALID, CNT0, DOUT1);
    else n_pass++;
    // Release channel 1: drain and reload in the same cycle.
    DIN = 32'h11111111; SEL = 1'b1; OUT1_READY = 1'b1;
    #1;
    n_total++;
    if (IN_READY !== 1'b1) $display("FAIL hol_release_ready: got %b want 1", IN_READY);
    else n_pass++;
    step();
    IN_VALID = 1'b0;
    n_total++;
    if (DOUT1 !== 32'h11111111 || OUT1_VALID !== 1'b1 || CNT1 !== 16'd2 || OUT0_VALID !== 1'b0)
      $display("FAIL hol_release_load: got d1=%h v1=%b c1=%0d v0=%b, want 11111111 1 2 0",
               DOUT1, OUT1_VALID, CNT1, OUT0_VALID);
    else n_pass++;
  endtask

  task automatic test_stream_wrap();
    int          bad;
    logic [31:0] w;
    bad = 0;
    do_reset();
    OUT0_READY = 1'b1; OUT1_READY = 1'b1;
    SEL = 1'b0; IN_VALID = 1'b1;
    for (int i = 0; i < 65536; i++) begin
      w = 32'(i) ^ 32'ha5a50000;
      DIN = w;
      #1;
      if (IN_READY !== 1'b1) bad++;
      step();
      if (OUT0_VALID !== 1'b1 || DOUT0 !== w || OUT1_VALID !== 1'b0) begin
        if (bad < 4)
          $display("FAIL stream_word[%0d]: got v0=%b d0=%h v1=%b, want 1 %h 0",
                   i, OUT0_VALID, DOUT0, OUT1_VALID, w);
        bad++;
      end
      if (i == 65534) begin
        n_total++;
        if (CNT0 !== 16'hffff) $display("FAIL stream_cnt_max: got %h want ffff", CNT0);
        else n_pass++;
      end
    end
    IN_VALID = 1'b0;
    n_total++;
    if (bad != 0) $display("FAIL stream_no_bubble: got %0d bad cycles, want 0", bad);
    else n_pass++;
    n_total++;
    if (CNT0 !== 16'h0000 || CNT1 !== 16'h0000)
      $display("FAIL stream_cnt_wrap: got c0=%h c1=%h, want 0000 0000", CNT0, CNT1);
    else n_pass++;
  endtask

  task automatic test_async_reset();
    do_reset();
    OUT0_READY = 1'b0; OUT1_READY = 1'b0;
    DIN = 32'h0a0a0a0a; SEL = 1'b0; IN_VALID = 1'b1;
    step();
    DIN = 32'h0b0b0b0b; SEL = 1'b1;
    step();
    n_total++;
    if (OUT0_VALID !== 1'b1 || OUT1_VALID !== 1'b1 || CNT0 !== 16'd1 || CNT1 !== 16'd1)
      $display("FAIL areset_setup: got v0=%b v1=%b c0=%0d c1=%0d, want 1 1 1 1",
               OUT0_VALID, OUT1_VALID, CNT0, CNT1);
    else n_pass++;
    #3;
    RST_N = 1'b0;
    #1;
    n_total++;
    if ({OUT0_VALID, OUT1_VALID, CNT0, CNT1, DOUT0, DOUT1} !== '0)
      $display("FAIL areset_immediate: got v0=%b v1=%b c0=%0d c1=%0d d0=%h d1=%h, want all 0",
               OUT0_VALID, OUT1_VALID, CNT0, CNT1, DOUT0, DOUT1);
    else n_pass++;
    IN_VALID = 1'b0; OUT0_READY = 1'b1; OUT1_READY = 1'b1;
    @(negedge CLK);
    RST_N = 1'b1;
    step();
    step();
    n_total++;
    if (OUT0_VALID !== 1'b0 || OUT1_VALID !== 1'b0 || CNT0 !== 16'd0 || CNT1 !== 16'd0)
      $display("FAIL areset_no_delivery: got v0=%b v1=%b c0=%0d c1=%0d, want 0 0 0 0",
               OUT0_VALID, OUT1_VALID, CNT0, CNT1);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_hol_block();
    test_stream_wrap();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
